// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned divider controller.
// Iterates a combinational 4-bit-per-pass restoring-division step over
// INPUT_SIZE/4 cycles. Owns the N/D/R/Q/I working registers and exposes a
// start/ready/busy/done handshake. A zero divisor completes in one cycle.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous reset, active-high
//   start       request, sampled only while ready=1
//   dividend    unsigned numerator N
//   divisor     unsigned denominator D
//   ready       high in IDLE and DONE
//   busy        high while iterating
//   done        one-cycle pulse when results become valid
//   quotient    floor(N/D), all ones on divide-by-zero
//   remainder   N mod D, N on divide-by-zero
//   div_by_zero set with done when D==0

// One restoring-division bit step: retires a single quotient bit, MSB first.
module div_seq_divunit #(
    parameter int unsigned W = 24
) (
    input  logic [W-1:0] i_n,
    input  logic [W-1:0] i_d,
    input  logic [W-1:0] i_r,
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_i,
    output logic [W-1:0] o_no,
    output logic [W-1:0] o_ro,
    output logic [W-1:0] o_qo,
    output logic [W-1:0] o_io
);
    logic [W:0] w_r_ext;
    logic [W:0] w_d_ext;
    logic       w_ge;

    // Shifted remainder needs one extra bit when D > 2^(W-1).
    assign w_r_ext = {i_r, i_n[W-1]};
    assign w_d_ext = {1'b0, i_d};
    assign w_ge    = (w_r_ext >= w_d_ext);

    // When not subtracting, w_r_ext < D so its top bit is zero.
    assign o_ro = w_ge ? W'(w_r_ext - w_d_ext) : w_r_ext[W-1:0];
    assign o_no = i_n << 1;
    assign o_qo = (i_q << 1) | W'(w_ge);
    assign o_io = i_i + W'(1);
endmodule

module div_seq_ctrl #(
    parameter int unsigned INPUT_SIZE = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [INPUT_SIZE-1:0] dividend,
    input  logic [INPUT_SIZE-1:0] divisor,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [INPUT_SIZE-1:0] quotient,
    output logic [INPUT_SIZE-1:0] remainder,
    output logic                  div_by_zero
);
    localparam int unsigned W     = INPUT_SIZE;
    localparam int unsigned ITER  = INPUT_SIZE / 4;
    localparam int unsigned UNITS = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic [W-1:0] r_n, r_d, r_r, r_q, r_i;
    logic [W-1:0] w_n_nxt, w_d_nxt, w_r_nxt, w_q_nxt, w_i_nxt;
    logic [W-1:0] r_quotient, r_remainder;
    logic [W-1:0] w_quotient_nxt, w_remainder_nxt;
    logic         r_ready, r_busy, r_done, r_dbz;
    logic         w_done_nxt, w_dbz_nxt;

    // Four chained bit steps form one pass of the datapath.
    logic [W-1:0] w_n_ch [0:UNITS];
    logic [W-1:0] w_r_ch [0:UNITS];
    logic [W-1:0] w_q_ch [0:UNITS];
    logic [W-1:0] w_i_ch [0:UNITS];

    assign w_n_ch[0] = r_n;
    assign w_r_ch[0] = r_r;
    assign w_q_ch[0] = r_q;
    assign w_i_ch[0] = r_i;

    for (genvar g = 0; g < UNITS; g++) begin : g_step
        div_seq_divunit #(.W(W)) u_divunit (
            .i_n  (w_n_ch[g]),
            .i_d  (r_d),
            .i_r  (w_r_ch[g]),
            .i_q  (w_q_ch[g]),
            .i_i  (w_i_ch[g]),
            .o_no (w_n_ch[g+1]),
            .o_ro (w_r_ch[g+1]),
            .o_qo (w_q_ch[g+1]),
            .o_io (w_i_ch[g+1])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_n_nxt         = r_n;
        w_d_nxt         = r_d;
        w_r_nxt         = r_r;
        w_q_nxt         = r_q;
        w_i_nxt         = r_i;
        w_quotient_nxt  = r_quotient;
        w_remainder_nxt = r_remainder;
        w_dbz_nxt       = r_dbz;
        w_done_nxt      = 1'b0;

        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (start) begin
                    w_n_nxt = dividend;
                    w_d_nxt = divisor;
                    w_r_nxt = '0;
                    w_q_nxt = '0;
                    w_i_nxt = '0;
                    if (divisor == '0) begin
                        w_state_nxt     = S_DONE;
                        w_quotient_nxt  = '1;
                        w_remainder_nxt = dividend;
                        w_dbz_nxt       = 1'b1;
                        w_done_nxt      = 1'b1;
                    end else begin
                        w_state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                w_n_nxt = w_n_ch[UNITS];
                w_r_nxt = w_r_ch[UNITS];
                w_q_nxt = w_q_ch[UNITS];
                w_i_nxt = w_i_ch[UNITS];
                // Final pass: all ITER*4 quotient bits retired.
                if (w_i_ch[UNITS] == W'(ITER * 4)) begin
                    w_state_nxt     = S_DONE;
                    w_quotient_nxt  = w_q_ch[UNITS];
                    w_remainder_nxt = w_r_ch[UNITS];
                    w_dbz_nxt       = 1'b0;
                    w_done_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Working registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_q         <= '0;
            r_i         <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_n         <= w_n_nxt;
            r_d         <= w_d_nxt;
            r_r         <= w_r_nxt;
            r_q         <= w_q_nxt;
            r_i         <= w_i_nxt;
            r_quotient  <= w_quotient_nxt;
            r_remainder <= w_remainder_nxt;
            r_dbz       <= w_dbz_nxt;
            r_done      <= w_done_nxt;
            r_ready     <= (w_state_nxt != S_CALC);
            r_busy      <= (w_state_nxt == S_CALC);
        end
    end

    assign ready       = r_ready;
    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_div_seq_ctrl;
    localparam int unsigned W = 24;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready, busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic prev_done = 1'b0;

    div_seq_ctrl #(.INPUT_SIZE(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            chk("done_one_cycle", 32'(prev_done), 32'd0);
            chk("ready_at_done", 32'(ready), 32'd1);
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
            end
        end
        prev_done <= rst ? 1'b0 : done;
    end

    // Wait for ready (bounded), then present a one-cycle start.
    task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input bit push);
        int k;
        k = 0;
        while (!ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!ready) chk("ready_timeout", 32'd0, 32'd1);
        start    = 1'b1;
        dividend = n;
        divisor  = d;
        if (push) sb_q.push_back('{q: eq, r: er, dbz: edbz});
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count busy negedges until done is seen (bounded).
    task automatic wait_done(output int busy_cycles);
        int k;
        busy_cycles = 0;
        k = 0;
        while (!done && k < 100) begin
            if (busy) busy_cycles++;
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    function automatic exp_t model(input logic [W-1:0] n, input logic [W-1:0] d);
        exp_t e;
        if (d == '0) begin
            e.q = '1; e.r = n; e.dbz = 1'b1;
        end else begin
            e.q = n / d; e.r = n % d; e.dbz = 1'b0;
        end
        return e;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   bc;
        exp_t e;
        logic [W-1:0] rn, rd;

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic 1000/7
        issue(24'd1000, 24'd7, 24'd142, 24'd6, 1'b0, 1'b1);
        wait_done(bc);
        chk("basic_busy_cycles", 32'(bc), 32'd6);
        @(negedge clk);
        chk("done_dropped", 32'(done), 32'd0);

        // Divide by zero: done immediately, no busy
        issue(24'h00ABCD, 24'd0, 24'hFFFFFF, 24'h00ABCD, 1'b1, 1'b1);
        wait_done(bc);
        chk("dbz_busy_cycles", 32'(bc), 32'd0);
        @(negedge clk);

        // Extremes and edge cases
        issue(24'hFFFFFF, 24'hFFFFFF, 24'd1, 24'd0, 1'b0, 1'b1);
        issue(24'hFFFFFF, 24'h800001, 24'd1, 24'h7FFFFE, 1'b0, 1'b1);
        issue(24'd5, 24'd9, 24'd0, 24'd5, 1'b0, 1'b1);
        issue(24'hFFFFFF, 24'd1, 24'hFFFFFF, 24'd0, 1'b0, 1'b1);
        issue(24'd0, 24'd5, 24'd0, 24'd0, 1'b0, 1'b1);
        wait_done(bc);
        chk("n0_full_busy", 32'(bc), 32'd6);
        @(negedge clk);

        // Handshake: starts during CALC are ignored
        issue(24'd5000, 24'd3, 24'd1666, 24'd2, 1'b0, 1'b1);
        start = 1'b1; dividend = 24'd99; divisor = 24'd3;     // CALC cycle 2
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; dividend = 24'd77; divisor = 24'd0;     // CALC cycle 4
        @(negedge clk);
        start = 1'b0;
        wait_done(bc);
        // Start on the done cycle is accepted immediately
        issue(24'd100, 24'd10, 24'd10, 24'd0, 1'b0, 1'b1);
        wait_done(bc);
        chk("b2b_busy_cycles", 32'(bc), 32'd6);
        @(negedge clk);

        // Reset on the third CALC cycle aborts without done
        issue(24'd1000, 24'd7, 24'd0, 24'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_dbz", 32'(div_by_zero), 32'd0);
        repeat (8) @(negedge clk);
        issue(24'd81, 24'd9, 24'd9, 24'd0, 1'b0, 1'b1);
        wait_done(bc);

        // Random back-to-back operations
        for (int i = 0; i < 5000; i++) begin
            rn = W'($urandom);
            rd = W'($urandom);
            if (i % 4 == 1) rd = W'($urandom_range(1, 255));
            if (rd == '0) rd = 24'd1;
            e = model(rn, rd);
            issue(rn, rd, e.q, e.r, e.dbz, 1'b1);
        end
        wait_done(bc);
        repeat (4) @(negedge clk);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
